// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache: 16 lines x 4 words, single memory port.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters; otherwise both read 0.
module dcache_controller (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [31:0]  cpu_addr,
   input  logic [31:0]  cpu_wdata,
   output logic [31:0]  cpu_rdata,
   output logic         cpu_stall,
   output logic         mem_rd_req,
   output logic         mem_wr_req,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ack,
   output logic [15:0]  hit_count,
   output logic [15:0]  miss_count,
   output logic [1:0]   fsm_state
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_BACK = 2'd1,
      ALLOCATE   = 2'd2
   } state_t;

   state_t state;

   logic [15:0]  valid;
   logic [15:0]  dirty;
   logic [23:0]  tag_mem  [16];
   logic [127:0] data_mem [16];

   logic [3:0]  index;
   logic [1:0]  word_sel;
   logic [6:0]  word_lsb;
   logic [23:0] addr_tag;
   logic        req;
   logic        hit;
   logic        wr_hit;
   logic        victim_dirty;
   logic        unused_addr_bits;

   assign index            = cpu_addr[7:4];
   assign word_sel         = cpu_addr[3:2];
   assign word_lsb         = {word_sel, 5'd0};
   assign addr_tag         = cpu_addr[31:8];
   assign unused_addr_bits = ^cpu_addr[1:0];

   assign req          = mem_read | mem_write;
   assign hit          = (state == IDLE) & req & valid[index] & (tag_mem[index] == addr_tag);
   assign wr_hit       = hit & mem_write;
   assign victim_dirty = valid[index] & dirty[index];

   // Read data is the pre-store word even when a store hits in the same cycle.
   assign cpu_rdata = hit ? data_mem[index][word_lsb +: 32] : 32'd0;
   assign cpu_stall = (state != IDLE) | (req & ~hit);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mem_rd_req <= 1'b0;
         mem_wr_req <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         valid      <= '0;
         dirty      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req && !hit) begin
                  if (victim_dirty) begin
                     state      <= WRITE_BACK;
                     mem_wr_req <= 1'b1;
                     mem_addr   <= {tag_mem[index], index};
                     mem_wdata  <= data_mem[index];
                  end else begin
                     state      <= ALLOCATE;
                     mem_rd_req <= 1'b1;
                     mem_addr   <= cpu_addr[31:4];
                  end
               end else if (wr_hit) begin
                  dirty[index] <= 1'b1;
               end
            end
            WRITE_BACK: begin
               if (mem_ack) begin
                  state      <= ALLOCATE;
                  mem_wr_req <= 1'b0;
                  mem_rd_req <= 1'b1;
                  mem_addr   <= cpu_addr[31:4];
               end
            end
            ALLOCATE: begin
               if (mem_ack) begin
                  state        <= IDLE;
                  mem_rd_req   <= 1'b0;
                  valid[index] <= 1'b1;
                  dirty[index] <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               mem_rd_req <= 1'b0;
               mem_wr_req <= 1'b0;
            end
         endcase
      end
   end

   // Tag and data storage carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (wr_hit) begin
         data_mem[index][word_lsb +: 32] <= cpu_wdata;
      end else if (state == ALLOCATE && mem_ack) begin
         data_mem[index] <= mem_rdata;
         tag_mem[index]  <= addr_tag;
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
         end
         if (state == IDLE && req && !hit && miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end
`else
   assign hit_count  = 16'd0;
   assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized scoreboard bench for dcache_controller with a line-level cache model and
// an auto-acknowledging memory responder that checks every block transfer.
module tb_dcache_controller;

   logic         clk;
   logic         rst_n;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  cpu_addr;
   logic [31:0]  cpu_wdata;
   logic [31:0]  cpu_rdata;
   logic         cpu_stall;
   logic         mem_rd_req;
   logic         mem_wr_req;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ack;
   logic [15:0]  hit_count;
   logic [15:0]  miss_count;
   logic [1:0]   fsm_state;

   dcache_controller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .mem_rd_req (mem_rd_req),
      .mem_wr_req (mem_wr_req),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .fsm_state  (fsm_state)
   );

   typedef struct {
      bit           wr;
      logic [27:0]  addr;
      logic [127:0] data;
   } xfer_t;

   logic [31:0] exp_q[$];
   xfer_t       mem_exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: cache contents as words, plus backing memory.
   bit           m_valid [16];
   bit           m_dirty [16];
   logic [23:0]  m_tag   [16];
   logic [31:0]  m_word  [16][4];
   logic [127:0] backing [logic [27:0]];
   int           m_hit  = 0;
   int           m_miss = 0;

   bit auto_ack    = 1;
   int fixed_delay = -1;
   int spur_req    = 0;
   int spur_done   = 0;

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic finish_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   function automatic logic [127:0] get_blk(input logic [27:0] blk);
      logic [127:0] v;
      if (backing.exists(blk)) return backing[blk];
      for (int w = 0; w < 4; w++) v[w*32 +: 32] = {blk, w[1:0], 2'b01};
      return v;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
      m_hit  = 0;
      m_miss = 0;
   endfunction

   // Driver: one CPU access, held until the cache stops stalling.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int stalls);
      logic [3:0]   idx;
      logic [23:0]  tg;
      int           w;
      logic [127:0] line;
      idx = addr[7:4];
      tg  = addr[31:8];
      w   = int'(addr[3:2]);
      if (!(m_valid[idx] && m_tag[idx] == tg)) begin
         m_miss++;
         if (m_valid[idx] && m_dirty[idx]) begin
            for (int k = 0; k < 4; k++) line[k*32 +: 32] = m_word[idx][k];
            backing[{m_tag[idx], idx}] = line;
            mem_exp_q.push_back('{1'b1, {m_tag[idx], idx}, line});
         end
         line = get_blk(addr[31:4]);
         mem_exp_q.push_back('{1'b0, addr[31:4], line});
         for (int k = 0; k < 4; k++) m_word[idx][k] = line[k*32 +: 32];
         m_valid[idx] = 1;
         m_dirty[idx] = 0;
         m_tag[idx]   = tg;
      end
      m_hit++;
      exp_q.push_back(m_word[idx][w]);
      if (wr) begin
         m_word[idx][w] = wdata;
         m_dirty[idx]   = 1;
      end
      mem_read  = rd;
      mem_write = wr;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      stalls    = 0;
      forever begin
         @(negedge clk);
         if (!cpu_stall) break;
         stalls++;
         if (stalls > 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, stalls);
            finish_run();
         end
      end
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   // Monitor: every completed access is compared against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && (mem_read || mem_write) && !cpu_stall) begin
            if (exp_q.size() == 0) begin
               check("unexpected_completion", 1, 0);
            end else begin
               check("cpu_rdata", cpu_rdata, exp_q.pop_front());
            end
         end
         if (mem_rd_req || mem_wr_req) check("req_exclusive", mem_rd_req & mem_wr_req, 0);
      end
   end

   // Memory responder: random latency, zero-wait allowed, checks each transfer.
   initial begin
      bit    in_xfer = 0;
      int    wait_left = 0;
      xfer_t cur;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (!rst_n) begin
            in_xfer = 0;
         end else if (auto_ack && (mem_rd_req || mem_wr_req)) begin
            if (!in_xfer) begin
               in_xfer   = 1;
               wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
               if (mem_exp_q.size() == 0) begin
                  check("unexpected_transfer", {mem_wr_req, mem_addr}, 0);
                  cur = '{mem_wr_req, mem_addr, '0};
               end else begin
                  cur = mem_exp_q.pop_front();
                  check("xfer_is_write", mem_wr_req, cur.wr);
                  check("xfer_addr", mem_addr, cur.addr);
                  if (cur.wr) check("xfer_wdata", mem_wdata, cur.data);
               end
            end
            if (wait_left == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = cur.wr ? $urandom() : cur.data;
               in_xfer   = 0;
            end else begin
               wait_left--;
            end
         end else if (spur_req != spur_done) begin
            mem_ack   = 1'b1;
            spur_done = spur_done + 1;
         end
      end
   end

   // Main stimulus
   initial begin
      int          st;
      logic [23:0] tg;
      logic [31:0] addr;
      bit          rd;
      bit          wr;
      rst_n     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      model_reset();
      backing[28'h0000010] = {32'h0B0B0B03, 32'h0A0A0A02, 32'hDEADBEEF, 32'h09090900};
      repeat (3) @(negedge clk);
      check("reset_state", fsm_state, 0);
      check("reset_reqs", {mem_rd_req, mem_wr_req}, 0);
      check("reset_counts", {hit_count, miss_count}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_stall", cpu_stall, 0);
      check("idle_rdata", cpu_rdata, 0);
      @(posedge clk);
      #1;

      // Cold read miss with a three-cycle memory
      fixed_delay = 2;
      do_access(1, 0, 32'h0000_0104, 32'h0, st);
      check("cold_miss_stall_cycles", st, 4);
      fixed_delay = -1;

      do_access(0, 1, 32'h0000_0108, 32'h1234_5678, st);
      check("write_hit_stall_cycles", st, 0);
      do_access(1, 0, 32'h0000_0108, 32'h0, st);
      check("read_after_write_stall", st, 0);

      // Conflict miss evicting the dirty line at index 0
      do_access(1, 0, 32'h0000_1100, 32'h0, st);
      check("dirty_evict_stalled", st > 0, 1);

      // Reset in the middle of an allocate
      auto_ack  = 0;
      mem_read  = 1'b1;
      cpu_addr  = 32'h0000_0204;
      @(negedge clk);
      check("miss_stall", cpu_stall, 1);
      @(posedge clk);
      #1;
      check("allocate_rd_req", mem_rd_req, 1);
      check("allocate_state", fsm_state, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_drops_reqs", {mem_rd_req, mem_wr_req}, 0);
      check("reset_to_idle", fsm_state, 0);
      check("reset_clears_counts", {hit_count, miss_count}, 0);
      mem_read = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      auto_ack = 1;
      do_access(1, 0, 32'h0000_0104, 32'h0, st);
      check("reread_after_reset_misses", st > 0, 1);

      // Spurious ack while idle, then read+write together on a hit
      spur_req = spur_req + 1;
      repeat (2) @(posedge clk);
      #1;
      check("spurious_ack_state", fsm_state, 0);
      check("spurious_ack_reqs", {mem_rd_req, mem_wr_req}, 0);
      do_access(1, 1, 32'h0000_0104, 32'hCAFE_F00D, st);
      check("rw_hit_stall_cycles", st, 0);
      do_access(1, 0, 32'h0000_0104, 32'h0, st);

      // Randomized traffic with a small tag pool to force conflicts
      for (int n = 0; n < 400; n++) begin
         tg   = 24'($urandom_range(0, 3));
         addr = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
         case ($urandom_range(0, 2))
            0:       begin rd = 1; wr = 0; end
            1:       begin rd = 0; wr = 1; end
            default: begin rd = 1; wr = 1; end
         endcase
         do_access(rd, wr, addr, $urandom(), st);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (2) @(negedge clk);
`ifdef DCACHE_STATS_EN
      check("hit_count", hit_count, (m_hit > 65535) ? 65535 : m_hit);
      check("miss_count", miss_count, (m_miss > 65535) ? 65535 : m_miss);
`else
      check("hit_count_tied", hit_count, 0);
      check("miss_count_tied", miss_count, 0);
`endif
      check("scoreboard_drained", exp_q.size(), 0);
      check("transfers_drained", mem_exp_q.size(), 0);
      finish_run();
   end

endmodule
